// File: rtl/code_lock_fsm.sv
// rtl/code_lock_fsm.sv - code lock sequencer fed by the 2-bit symbol comparator
// Tracks key position, unlock window, failed-attempt count and timed alarm lockout.
module code_lock_fsm #(
  parameter int CODE_LEN       = 4,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           digit_valid,
  input  logic                           match,
  input  logic                           relock,
  output logic [$clog2(CODE_LEN)-1:0]    key_idx,
  output logic                           unlocked,
  output logic                           alarm,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

  localparam int KW   = $clog2(CODE_LEN);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ENTRY;
      key_idx  <= '0;
      unlocked <= 1'b0;
      alarm    <= 1'b0;
      fail_cnt <= '0;
      timer    <= '0;
    end else begin
      case (state)
        ENTRY: begin
          if (digit_valid) begin
            if (match) begin
              if (key_idx == KW'(CODE_LEN - 1)) begin
                state    <= UNLOCKED;
                key_idx  <= '0;
                fail_cnt <= '0;
                timer    <= TW'(UNLOCK_CYCLES - 1);
                unlocked <= 1'b1;
              end else begin
                key_idx <= key_idx + 1'b1;
              end
            end else begin
              // A mismatch anywhere in the sequence restarts the attempt.
              key_idx <= '0;
              if (fail_cnt == FW'(MAX_FAILS - 1)) begin
                state    <= LOCKOUT;
                fail_cnt <= '0;
                timer    <= TW'(LOCKOUT_CYCLES - 1);
                alarm    <= 1'b1;
              end else begin
                fail_cnt <= fail_cnt + 1'b1;
              end
            end
          end
        end
        UNLOCKED: begin
          if (relock || timer == '0) begin
            state    <= ENTRY;
            unlocked <= 1'b0;
            timer    <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        LOCKOUT: begin
          if (timer == '0) begin
            state <= ENTRY;
            alarm <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state    <= ENTRY;
          key_idx  <= '0;
          unlocked <= 1'b0;
          alarm    <= 1'b0;
          fail_cnt <= '0;
          timer    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock_fsm.sv
// tb/tb_code_lock_fsm.sv - directed self-checking bench for code_lock_fsm
module tb_code_lock_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       digit_valid = 1'b0;
  logic       match = 1'b0;
  logic       relock = 1'b0;
  logic [1:0] key_idx;
  logic       unlocked;
  logic       alarm;
  logic [1:0] fail_cnt;

  int checks = 0;
  int failures = 0;

  code_lock_fsm #(
    .CODE_LEN(4), .MAX_FAILS(3), .UNLOCK_CYCLES(8), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .match(match), .relock(relock),
    .key_idx(key_idx), .unlocked(unlocked), .alarm(alarm), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle strobe; returns at the negedge after it was consumed.
  task automatic strobe(input logic m);
    @(negedge clk);
    digit_valid = 1'b1;
    match = m;
    @(negedge clk);
    digit_valid = 1'b0;
    match = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_key"}, key_idx, 0);
    check({tag, "_unl"}, unlocked, 0);
    check({tag, "_alm"}, alarm, 0);
    check({tag, "_fail"}, fail_cnt, 0);
  endtask

  initial begin
    // 1. reset
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // 2. full correct code, unlock window of 8 cycles
    for (int i = 1; i <= 3; i++) begin
      strobe(1'b1);
      check($sformatf("step_key%0d", i), key_idx, i);
    end
    strobe(1'b1);
    check("unl_first", unlocked, 1);
    check("unl_key0", key_idx, 0);
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("unl_cyc%0d", i), unlocked, 1);
    end
    @(negedge clk);
    check("unl_end", unlocked, 0);

    // 3. partial then mismatch, then success clears fail_cnt
    strobe(1'b1); check("p_key1", key_idx, 1);
    strobe(1'b1); check("p_key2", key_idx, 2);
    strobe(1'b0); check("p_key0", key_idx, 0);
    check("p_fail1", fail_cnt, 1);
    repeat (4) strobe(1'b1);
    check("p_unl", unlocked, 1);
    check("p_fail0", fail_cnt, 0);
    repeat (8) @(negedge clk);
    check("p_unl_end", unlocked, 0);

    // 4. three mismatches lead to 16-cycle lockout
    strobe(1'b0); check("lk_fail1", fail_cnt, 1);
    strobe(1'b0); check("lk_fail2", fail_cnt, 2);
    strobe(1'b0);
    check("lk_alarm", alarm, 1);
    check("lk_fail0", fail_cnt, 0);
    strobe(1'b1); check("lk_ign_key1", key_idx, 0);
    relock = 1'b1;
    strobe(1'b1); check("lk_ign_key2", key_idx, 0);
    relock = 1'b0;
    for (int i = 5; i <= 15; i++) begin
      @(negedge clk);
      check($sformatf("lk_cyc%0d", i), alarm, 1);
      check($sformatf("lk_nounl%0d", i), unlocked, 0);
    end
    @(negedge clk);
    check("lk_end", alarm, 0);
    check("lk_end_key", key_idx, 0);

    // 5. relock on the third unlocked cycle
    repeat (4) strobe(1'b1);
    check("rl_unl1", unlocked, 1);
    @(negedge clk);
    check("rl_unl2", unlocked, 1);
    @(negedge clk);
    check("rl_unl3", unlocked, 1);
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    check("rl_off", unlocked, 0);
    strobe(1'b1);
    check("rl_entry_key", key_idx, 1);

    // 6. reset mid-entry and mid-lockout
    strobe(1'b1);
    check("mr_key2", key_idx, 2);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("mr_entry");
    rst = 1'b0;
    repeat (3) strobe(1'b0);
    check("mr_alarm", alarm, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("mr_lock");
    rst = 1'b0;
    @(negedge clk);
    check("mr_post_alarm", alarm, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
